// File: rtl/keypad_press_emulator.sv
// Keypad responder: on request, closes one key contact of a 4x4 active-low scan matrix for a timed press.
// Optional contact bounce at make/break is built in only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_press_emulator #(
    parameter int HOLD_CYCLES    = 1000,
    parameter int RELEASE_CYCLES = 1000,
    parameter int BOUNCE_CYCLES  = 16,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [1:0] key_row,
    input  logic [1:0] key_col,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       busy,
    output logic       press_done,
    output logic [7:0] press_count
);

    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int REL_EFF  = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
    localparam int BNC_EFF  = (BOUNCE_CYCLES < 1) ? 1 : BOUNCE_CYCLES;
    localparam int MAX_PH   = (HOLD_EFF > REL_EFF) ? ((HOLD_EFF > BNC_EFF) ? HOLD_EFF : BNC_EFF)
                                                   : ((REL_EFF > BNC_EFF) ? REL_EFF : BNC_EFF);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] REL_LD  = CNT_W'(REL_EFF - 1);

    // Elaboration-time guard: the phase counter and toggle counter must fit their parameters.
    if ((CNT_W < 31 && (MAX_PH - 1) > ((1 << CNT_W) - 1)) ||
        BOUNCE_TOGGLES < 0 || BOUNCE_TOGGLES > 65535) begin : g_param_check
        $error("keypad_press_emulator: CNT_W too small or BOUNCE_TOGGLES out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_BOUNCE_IN  = 3'd3,
        ST_BOUNCE_OUT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [1:0]       key_col_q, key_col_d;
    logic [3:0]       row_q, row_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       count_q, count_d;
    logic             closed_s;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BNC_LD   = CNT_W'(BNC_EFF - 1);
    localparam logic [15:0]      TOG_LAST = 16'(BOUNCE_TOGGLES - 1);
    localparam bit               BNC_ON   = (BOUNCE_TOGGLES > 0);
    logic [15:0] tog_q, tog_d;
`endif

    // Next-state, phase counting and contact model.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
        done_d    = 1'b0;
        count_d   = count_q;
        closed_s  = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        tog_d     = tog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    key_row_d = key_row;
                    key_col_d = key_col;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    if (BNC_ON) begin
                        state_d = ST_BOUNCE_IN;
                        cnt_d   = BNC_LD;
                        tog_d   = 16'd0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end
`else
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                closed_s = 1'b1;
                if (cnt_q == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    if (BNC_ON) begin
                        state_d = ST_BOUNCE_OUT;
                        cnt_d   = BNC_LD;
                        tog_d   = 16'd0;
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = REL_LD;
                    end
`else
                    state_d = ST_RELEASE;
                    cnt_d   = REL_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            // Bounce-in starts closed, bounce-out starts open; contact flips every phase.
            ST_BOUNCE_IN: begin
                closed_s = ~tog_q[0];
                if (cnt_q == '0) begin
                    if (tog_q == TOG_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        tog_d = tog_q + 16'd1;
                        cnt_d = BNC_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BOUNCE_OUT: begin
                closed_s = tog_q[0];
                if (cnt_q == '0) begin
                    if (tog_q == TOG_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = REL_LD;
                    end else begin
                        tog_d = tog_q + 16'd1;
                        cnt_d = BNC_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Row drive and handshake flags derived from the contact and next state.
    always_comb begin
        row_d = 4'b1111;
        if (closed_s) begin
            row_d[key_row_q] = col_in[key_col_q];
        end else begin
            row_d = 4'b1111;
        end
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_row_q <= 2'd0;
            key_col_q <= 2'd0;
            row_q     <= 4'b1111;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 8'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            tog_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            row_q     <= row_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
            tog_q     <= tog_d;
`endif
        end
    end

    assign row_out     = row_q;
    assign key_ready   = ready_q;
    assign busy        = busy_q;
    assign press_done  = done_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_keypad_press_emulator.sv
// Self-checking bench for keypad_press_emulator; reference model is a per-press contact schedule queue.
module tb_keypad_press_emulator;

    localparam int HOLD = 4;
    localparam int REL  = 3;
    localparam int BCY  = 2;
    localparam int BTOG = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int LAT = HOLD + REL + 2 * BTOG * BCY + 1;
`else
    localparam int LAT = HOLD + REL + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       busy;
    logic       press_done;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    keypad_press_emulator #(
        .HOLD_CYCLES   (HOLD),
        .RELEASE_CYCLES(REL),
        .BOUNCE_CYCLES (BCY),
        .BOUNCE_TOGGLES(BTOG),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_row    (key_row),
        .key_col    (key_col),
        .col_in     (col_in),
        .row_out    (row_out),
        .busy       (busy),
        .press_done (press_done),
        .press_count(press_count)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a press is a queue of per-cycle contact states (1 = closed).
    bit         m_sched[$];
    bit         m_busy;
    bit         m_closed;
    bit         m_accepted;
    logic [1:0] m_row;
    logic [1:0] m_col;
    logic [3:0] e_row;
    bit         e_done;
    logic [7:0] e_count;

    function automatic void model_reset();
        m_sched.delete();
        m_busy     = 1'b0;
        m_closed   = 1'b0;
        m_accepted = 1'b0;
        m_row      = 2'd0;
        m_col      = 2'd0;
        e_row      = 4'b1111;
        e_done     = 1'b0;
        e_count    = 8'd0;
    endfunction

    function automatic void build_schedule();
`ifdef KEYPAD_EMU_BOUNCE_EN
        for (int p = 0; p < BTOG; p++)
            for (int c = 0; c < BCY; c++) m_sched.push_back((p % 2) == 0);
`endif
        for (int c = 0; c < HOLD; c++) m_sched.push_back(1'b1);
`ifdef KEYPAD_EMU_BOUNCE_EN
        for (int p = 0; p < BTOG; p++)
            for (int c = 0; c < BCY; c++) m_sched.push_back((p % 2) == 1);
`endif
        for (int c = 0; c < REL; c++) m_sched.push_back(1'b0);
    endfunction

    function automatic void model_edge();
        logic [3:0] r;
        r = 4'b1111;
        if (m_closed) r[m_row] = col_in[m_col];
        e_row      = r;
        e_done     = 1'b0;
        m_accepted = 1'b0;
        if (!m_busy && key_valid) begin
            m_row = key_row;
            m_col = key_col;
            build_schedule();
            m_accepted = 1'b1;
        end
        if (m_sched.size() > 0) begin
            m_closed = m_sched.pop_front();
            m_busy   = 1'b1;
        end else begin
            if (m_busy) begin
                e_done  = 1'b1;
                e_count = e_count + 8'd1;
            end
            m_busy   = 1'b0;
            m_closed = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("row_out", {28'd0, row_out}, {28'd0, e_row});
        chk("key_ready", {31'd0, key_ready}, {31'd0, !m_busy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("press_done", {31'd0, press_done}, {31'd0, e_done});
        chk("press_count", {24'd0, press_count}, {24'd0, e_count});
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Request a key, drop valid once accepted, then time the press until press_done.
    task automatic do_press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] ci);
        int lat;
        key_row   = r;
        key_col   = c;
        col_in    = ci;
        key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_accepted) break;
        end
        key_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!press_done && lat < 200) begin
            step();
            lat++;
        end
        chk("press_latency", lat, LAT);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_row   = 2'd0;
        key_col   = 2'd0;
        col_in    = 4'b1111;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Idle while the scanner walks its columns.
        for (int i = 0; i < 8; i++) begin
            col_in = ~(4'b0001 << (i % 4));
            step();
        end

        // Key (1,2) with column 2 driven, then with only column 0 driven.
        do_press(2'd1, 2'd2, 4'b1011);
        step();
        do_press(2'd1, 2'd2, 4'b1110);
        step();

        // New request held during busy: accepted only once back in IDLE.
        key_row   = 2'd0;
        key_col   = 2'd3;
        col_in    = 4'b0111;
        key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_accepted) break;
        end
        key_row = 2'd2;
        key_col = 2'd1;
        col_in  = 4'b1101;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_accepted) break;
        end
        key_valid = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) step();

        // Reset in the third HOLD cycle aborts the press.
        key_row   = 2'd3;
        key_col   = 2'd0;
        col_in    = 4'b0000;
        key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_accepted) break;
        end
        key_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();

        // Random columns, keys and requests, including requests during busy.
        for (int i = 0; i < 400; i++) begin
            col_in    = 4'($urandom);
            key_row   = 2'($urandom);
            key_col   = 2'($urandom);
            key_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        // Back-to-back presses until the press counter wraps.
        key_valid = 1'b1;
        for (int i = 0; i < 260 * LAT; i++) begin
            col_in  = 4'($urandom);
            key_row = 2'($urandom);
            key_col = 2'($urandom);
            step();
        end
        key_valid = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
